// File: rtl/qpsk_symbol_framer_if.sv
// Handshake and symbol-stream bundle for qpsk_symbol_framer.
// The master side is the byte source / modulator; the slave side is the framer.
interface qpsk_symbol_framer_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    data_in;
    logic          data_valid;
    logic          data_ready;
    logic          start;
    logic [7:0]    frame_len;
    logic          mod_req;
    logic [1:0]    symbol_out;
    logic          symbol_en;
    logic          busy;
    logic          done;
    logic          underrun;
    logic [LW-1:0] fifo_level;

    modport master (
        output data_in, data_valid, start, frame_len, mod_req,
        input  data_ready, symbol_out, symbol_en, busy, done, underrun, fifo_level
    );

    modport slave (
        input  data_in, data_valid, start, frame_len, mod_req,
        output data_ready, symbol_out, symbol_en, busy, done, underrun, fifo_level
    );
endinterface

// File: rtl/qpsk_symbol_framer.sv
// QPSK frame builder: preamble, sync word, then FIFO-fed payload bytes,
// one 2-bit symbol per modulator strobe.
module qpsk_symbol_framer #(
    parameter int          PREAMBLE_SYMS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hD391,
    parameter int          FIFO_DEPTH    = 16
) (
    input logic            clk,
    input logic            reset,
    qpsk_symbol_framer_if.slave bus
);
    localparam int         AW  = $clog2(FIFO_DEPTH);
    localparam int         LW  = AW + 1;
    localparam logic [7:0] PRE = 8'(PREAMBLE_SYMS);

    typedef enum logic [2:0] {IDLE, ARMED, PREAMBLE, SYNC, PAYLOAD, TAIL} state_t;

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n, left, left_n, cur, cur_n;
    logic [1:0]    pidx, pidx_n, sym, sym_n;
    logic          en, en_n, done_r, done_n, und, und_n;
    logic          pop, push, empty, need_byte;
    logic [7:0]    pay_sh, rd_data;
    logic [15:0]   sync_sh;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;

    assign empty          = (level == '0);
    assign bus.data_ready = (level != LW'(FIFO_DEPTH));
    assign push           = bus.data_valid && bus.data_ready;
    assign rd_data        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (!push && pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            left   <= '0;
            cur    <= '0;
            pidx   <= '0;
            sym    <= 2'b00;
            en     <= 1'b0;
            done_r <= 1'b0;
            und    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            left   <= left_n;
            cur    <= cur_n;
            pidx   <= pidx_n;
            sym    <= sym_n;
            en     <= en_n;
            done_r <= done_n;
            und    <= und_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        left_n    = left;
        cur_n     = cur;
        pidx_n    = pidx;
        sym_n     = sym;
        en_n      = en;
        done_n    = 1'b0;
        und_n     = 1'b0;
        pop       = 1'b0;
        need_byte = 1'b0;
        pay_sh    = cur << {pidx, 1'b0};
        sync_sh   = SYNC_WORD << {cnt[2:0], 1'b0};
        case (state)
            IDLE: if (bus.start && bus.frame_len != 8'd0) begin
                state_n = ARMED;
                left_n  = bus.frame_len;
            end
            ARMED: if (bus.mod_req) begin
                state_n = PREAMBLE;
                sym_n   = 2'b00;
                en_n    = 1'b1;
                cnt_n   = 8'd1;
            end
            PREAMBLE: if (bus.mod_req) begin
                if (cnt == PRE) begin
                    state_n = SYNC;
                    sym_n   = SYNC_WORD[15:14];
                    cnt_n   = 8'd1;
                end else begin
                    sym_n = cnt[0] ? 2'b10 : 2'b00;
                    cnt_n = cnt + 8'd1;
                end
            end
            SYNC: if (bus.mod_req) begin
                if (cnt == 8'd8) need_byte = 1'b1;
                else begin
                    sym_n = sync_sh[15:14];
                    cnt_n = cnt + 8'd1;
                end
            end
            PAYLOAD: if (bus.mod_req) begin
                if (pidx != 2'd0) begin
                    sym_n  = pay_sh[7:6];
                    pidx_n = pidx + 2'd1;
                end else if (left == 8'd0) begin
                    state_n = TAIL;
                    sym_n   = 2'b00;
                    en_n    = 1'b0;
                    done_n  = 1'b1;
                end else need_byte = 1'b1;
            end
            TAIL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A byte is fetched on the strobe that emits its first pair; an empty
        // FIFO at that moment aborts the frame without touching its contents.
        if (need_byte) begin
            if (empty) begin
                state_n = IDLE;
                sym_n   = 2'b00;
                en_n    = 1'b0;
                und_n   = 1'b1;
            end else begin
                state_n = PAYLOAD;
                pop     = 1'b1;
                cur_n   = rd_data;
                sym_n   = rd_data[7:6];
                pidx_n  = 2'd1;
                left_n  = left - 8'd1;
            end
        end
    end

    assign bus.symbol_out = sym;
    assign bus.symbol_en  = en;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_r;
    assign bus.underrun   = und;
    assign bus.fifo_level = level;
endmodule

// File: tb/tb_qpsk_symbol_framer.sv
// Self-checking bench for qpsk_symbol_framer: directed frames plus randomized
// frames compared against a symbol-list model built from the frame rules.
module tb_qpsk_symbol_framer;
    localparam int          P     = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] SW    = 16'hD391;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qpsk_symbol_framer_if #(.FIFO_DEPTH(DEPTH)) bus ();
    qpsk_symbol_framer #(.PREAMBLE_SYMS(P), .SYNC_WORD(SW), .FIFO_DEPTH(DEPTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int exp_done = 0;
    byte unsigned q[$];

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input byte unsigned b);
        int t = 0;
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        while (!bus.data_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("push_timeout", 0, 1);
        @(negedge clk);
        bus.data_valid = 1'b0;
        q.push_back(b);
    endtask

    task automatic strobe();
        bus.mod_req = 1'b1;
        @(negedge clk);
        bus.mod_req = 1'b0;
    endtask

    // Expected symbols: alternating preamble, sync pairs MSB first, then
    // four pairs per available byte; the strobe after the list ends the frame.
    task automatic play(input int len, input int gap, input int mid_start);
        logic [1:0]  e[$];
        logic [15:0] s;
        byte unsigned b;
        int avail, en_hi;
        avail = (q.size() < len) ? q.size() : len;
        en_hi = 0;
        for (int i = 0; i < P; i++) e.push_back((i % 2) ? 2'b10 : 2'b00);
        for (int k = 0; k < 8; k++) begin
            s = SW >> (14 - 2 * k);
            e.push_back(s[1:0]);
        end
        for (int n = 0; n < avail; n++) begin
            b = q.pop_front();
            for (int j = 0; j < 4; j++) e.push_back(2'((b >> (6 - 2 * j)) & 8'h3));
        end
        foreach (e[i]) begin
            strobe();
            chk("sym", bus.symbol_out, e[i]);
            if (bus.symbol_en === 1'b1) en_hi++;
            if (bus.done !== 1'b0 || bus.underrun !== 1'b0) chk("no_pulse", {bus.done, bus.underrun}, 0);
            if (i == mid_start) begin
                bus.start = 1'b1;
                bus.frame_len = 8'd5;
                @(negedge clk);
                bus.start = 1'b0;
                chk("busy_mid_start", bus.busy, 1);
            end
            idle(gap - 1);
            chk("hold", bus.symbol_out, e[i]);
        end
        chk("en_periods", en_hi, e.size());
        strobe();
        if (avail == len) begin
            exp_done++;
            chk("done", bus.done, 1);
            chk("und_at_done", bus.underrun, 0);
            chk("en_tail", bus.symbol_en, 0);
            chk("sym_tail", bus.symbol_out, 0);
            @(negedge clk);
            chk("busy_after", bus.busy, 0);
            chk("done_1cyc", bus.done, 0);
        end else begin
            chk("underrun", bus.underrun, 1);
            chk("done_at_und", bus.done, 0);
            chk("en_abort", bus.symbol_en, 0);
            chk("sym_abort", bus.symbol_out, 0);
            chk("busy_abort", bus.busy, 0);
            chk("level_abort", bus.fifo_level, q.size());
        end
    endtask

    task automatic frame(input int len, input int gap, input int mid_start, input bit same_cycle);
        bus.start     = 1'b1;
        bus.frame_len = 8'(len);
        bus.mod_req   = same_cycle;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.mod_req = 1'b0;
        chk("busy_start", bus.busy, 1);
        chk("no_sym_armed", bus.symbol_en, 0);
        idle(2);
        chk("armed_quiet", bus.symbol_en, 0);
        play(len, gap, mid_start);
    endtask

    initial begin
        byte unsigned b17, bp;
        int len, nb;
        reset = 1'b1;
        bus.data_in = '0; bus.data_valid = 1'b0; bus.start = 1'b0;
        bus.frame_len = '0; bus.mod_req = 1'b0;
        idle(2);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_ready", bus.data_ready, 1);
        chk("rst_en", bus.symbol_en, 0);
        chk("rst_sym", bus.symbol_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pulses", {bus.done, bus.underrun}, 0);
        reset = 1'b0;
        idle(1);

        // Reference frame with the published symbol sequence
        push(8'hB4); push(8'h1E);
        chk("level2", bus.fifo_level, 2);
        frame(2, 100, -1, 1'b0);

        // Underrun on the third byte
        push(8'($urandom)); push(8'($urandom));
        frame(3, 3, -1, 1'b0);

        // Ignored starts
        bus.start = 1'b1; bus.frame_len = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("len0_busy", bus.busy, 0);
        idle(3);
        chk("len0_busy_late", bus.busy, 0);
        push(8'($urandom)); push(8'($urandom));
        frame(2, 3, 5, 1'b0);
        idle(4);
        chk("no_restart", bus.busy, 0);

        // start and mod_req in the same cycle
        push(8'($urandom));
        frame(1, 2, -1, 1'b1);

        // Fill to full, hold a 17th byte until a pop frees a slot
        for (int i = 0; i < 16; i++) push(8'($urandom));
        chk("full_level", bus.fifo_level, 16);
        chk("full_ready", bus.data_ready, 0);
        b17 = 8'($urandom);
        bus.data_in = b17; bus.data_valid = 1'b1;
        idle(5);
        chk("held_level", bus.fifo_level, 16);
        bus.start = 1'b1; bus.frame_len = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < P + 8; i++) strobe();
        bp = q.pop_front();
        strobe();
        chk("pop_sym", bus.symbol_out, bp[7:6]);
        chk("pop_level", bus.fifo_level, 15);
        chk("pop_ready", bus.data_ready, 1);
        @(negedge clk);
        bus.data_valid = 1'b0;
        q.push_back(b17);
        chk("refill_level", bus.fifo_level, 16);
        for (int i = 0; i < 3; i++) strobe();
        strobe();
        exp_done++;
        chk("full_done", bus.done, 1);
        idle(1);
        frame(16, 1, -1, 1'b0);

        // Reset in the middle of the payload
        for (int i = 0; i < 3; i++) push(8'($urandom));
        bus.start = 1'b1; bus.frame_len = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < P + 8 + 2; i++) strobe();
        chk("pre_rst_en", bus.symbol_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_en", bus.symbol_en, 0);
        chk("mid_rst_sym", bus.symbol_out, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_level", bus.fifo_level, 0);
        chk("mid_rst_ready", bus.data_ready, 1);
        chk("mid_rst_pulses", {bus.done, bus.underrun}, 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        idle(3);
        chk("no_resume", bus.busy, 0);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        frame(3, 2, -1, 1'b0);

        // Randomized frames, occasionally one byte short
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 6);
            nb  = ($urandom_range(0, 3) == 0) ? len - 1 : len;
            for (int i = 0; i < nb; i++) push(8'($urandom));
            frame(len, $urandom_range(1, 4), -1, 1'b0);
            idle(2);
        end

        chk("done_count", done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/qpsk_symbol_framer.md
QPSK_SYMBOL_FRAMER -- requirements
Module: qpsk_symbol_framer

Interface
REQ-001 The block SHALL have parameter PREAMBLE_SYMS, default 16, giving the number of preamble symbols per frame (range 2..255).
REQ-002 The block SHALL have parameter SYNC_WORD, default 16'hD391, giving the 16-bit sync word sent after the preamble.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, giving the payload byte FIFO depth (power of two).
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 data_in  in  8  payload byte.
REQ-007 data_valid  in  1  data_in valid; byte is accepted when data_valid && data_ready.
REQ-008 data_ready  out  1  FIFO not full.
REQ-009 start  in  1  one-cycle frame request.
REQ-010 frame_len  in  8  payload byte count, sampled with start.
REQ-011 mod_req  in  1  one-cycle symbol-boundary strobe from the modulator.
REQ-012 symbol_out  out  2  current QPSK symbol.
REQ-013 symbol_en  out  1  level-high while a frame symbol is on symbol_out.
REQ-014 busy  out  1  high from accepted start until return to IDLE.
REQ-015 done  out  1  one-cycle pulse at normal frame completion.
REQ-016 underrun  out  1  one-cycle pulse at frame abort on FIFO empty.
REQ-017 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 The block SHALL implement states IDLE, ARMED, PREAMBLE, SYNC, PAYLOAD, TAIL.
REQ-019 In IDLE, start with frame_len != 0 SHALL latch frame_len and move to ARMED; start with frame_len == 0 is ignored; start in any other state is ignored.
REQ-020 In ARMED, the next mod_req SHALL move to PREAMBLE and emit the first preamble symbol; mod_req in the same cycle as start does not count.
REQ-021 Every symbol change SHALL appear on symbol_out and symbol_en one clock after the cycle where mod_req is high, and is held stable until the next mod_req.
REQ-022 symbol_en SHALL be continuously high from the first preamble symbol through the whole period of the last payload symbol, because the modulator reverts to phase 00 whenever symbol_en is low.
REQ-023 The preamble SHALL alternate 2'b00, 2'b10, starting with 2'b00, for exactly PREAMBLE_SYMS symbols.
REQ-024 The sync word SHALL be sent as 8 symbols, MSB pair first (SYNC_WORD[15:14] first, [1:0] last).
REQ-025 In PAYLOAD, each byte SHALL be popped from the FIFO on the mod_req that emits its first symbol and sent as bits [7:6], [5:4], [3:2], [1:0].
REQ-026 The total symbols in a frame SHALL be PREAMBLE_SYMS + 8 + 4*frame_len.
REQ-027 On the mod_req after the last payload symbol, the block SHALL go to TAIL: symbol_en falls to 0, symbol_out goes to 00, and done pulses; the next clock returns the block to IDLE with busy low.
REQ-028 If a byte is needed and the FIFO is empty, the block SHALL abort the frame on that mod_req: symbol_en falls to 0, symbol_out goes to 00, underrun pulses, the state goes to IDLE, and the FIFO contents are retained.
REQ-029 FIFO push and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-030 A push when full SHALL be impossible, since data_ready is low; the FIFO SHALL NOT be pushed even if a pop occurs in the same cycle.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 done and underrun SHALL never be high in the same cycle.

Reset
REQ-033 Asserting reset in any state SHALL immediately set: state IDLE, FIFO empty, fifo_level 0, data_ready 1, symbol_out 00, symbol_en 0, busy 0, done 0, underrun 0.
REQ-034 A frame interrupted by reset SHALL NOT resume, and no done or underrun pulse is produced for it.

Verification
REQ-035 The bench SHALL push 2 bytes 8'hB4, 8'h1E, start with frame_len=2, PREAMBLE_SYMS=4, and mod_req every 100 clocks; the required sequence is 00,10,00,10, 11,01,00,11,10,01,00,01, 10,11,01,00, 00,01,11,10, then done, with 20 symbol_en-high periods.
REQ-036 The bench SHALL start with frame_len=3 with only 2 bytes queued; underrun pulses on the mod_req for byte 3, symbol_en drops one clock later, and done never pulses.
REQ-037 The bench SHALL push 17 bytes with no pops; data_ready goes low after 16, fifo_level=16, and the 17th byte is held until a pop occurs.
REQ-038 The bench SHALL apply start and mod_req in the same cycle; no symbol is emitted, and the first preamble symbol appears one clock after the following mod_req.
REQ-039 The bench SHALL assert reset mid-PAYLOAD; on the same edge all outputs reach their reset values and fifo_level=0, and after a new start with fresh bytes the full frame is correct.
REQ-040 The bench SHALL apply start with frame_len=0, and start during busy; both are ignored, busy is unchanged, and there is no extra done pulse.
